// File: rtl/shared_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : shared_mem_arbiter_if
//  Purpose  : IF/MEM request channels plus the shared RAM port of the arbiter.
//  Revision : 1.0
// ============================================================================
interface shared_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;
   logic              if_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_stall;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              busy;
   logic              last_grant_mem;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
             ram_en, ram_we, ram_addr, ram_wdata, busy, last_grant_mem
   );

   // Pipeline stages and RAM macro side
   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
             ram_en, ram_we, ram_addr, ram_wdata, busy, last_grant_mem
   );
endinterface
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_mem_arbiter
//  Purpose  : Shares one fixed-latency single-port RAM between IF and MEM
//             stages; MEM has priority, alternating when both keep asking.
//  Revision : 1.0
// ============================================================================
module shared_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 3     // legal range 1..15
) (
   input  logic                clk,
   input  logic                rst,
   shared_mem_arbiter_if.slave bus
);
   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_ISSUE = 2'd1;
   localparam logic [1:0] c_S_WAIT  = 2'd2;
   localparam logic [1:0] c_S_DONE  = 2'd3;

   localparam int                 c_CNT_W = 4;
   localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MEM_LAT);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_grant_mem;
   logic               r_last_grant_mem;
   logic               r_ram_we;
   logic [ADDR_W-1:0]  r_ram_addr;
   logic [DATA_W-1:0]  r_ram_wdata;
   logic [DATA_W-1:0]  r_if_rdata;
   logic [DATA_W-1:0]  r_mem_rdata;

   logic w_any_req;
   logic w_pick_mem;
   logic w_done;
   logic w_if_ready;
   logic w_mem_ready;

   // MEM wins a tie unless it also took the previous grant
   assign w_any_req   = bus.if_req | bus.mem_req;
   assign w_pick_mem  = bus.mem_req & (~bus.if_req | ~r_last_grant_mem);
   assign w_done      = (r_state == c_S_DONE);
   // A requester that dropped its req (flush) gets no pulse
   assign w_if_ready  = w_done & ~r_grant_mem & bus.if_req;
   assign w_mem_ready = w_done &  r_grant_mem & bus.mem_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= c_S_IDLE;
         r_cnt            <= '0;
         r_grant_mem      <= 1'b0;
         r_last_grant_mem <= 1'b0;
         r_ram_we         <= 1'b0;
         r_ram_addr       <= '0;
         r_ram_wdata      <= '0;
         r_if_rdata       <= '0;
         r_mem_rdata      <= '0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_any_req) begin
                  r_grant_mem      <= w_pick_mem;
                  r_last_grant_mem <= w_pick_mem;
                  r_ram_addr       <= w_pick_mem ? bus.mem_addr : bus.if_addr;
                  r_ram_we         <= w_pick_mem & bus.mem_we;
                  r_ram_wdata      <= w_pick_mem ? bus.mem_wdata : '0;
                  r_state          <= c_S_ISSUE;
               end
            end
            c_S_ISSUE: begin
               r_cnt   <= c_LAT;
               r_state <= c_S_WAIT;
            end
            c_S_WAIT: begin
               r_cnt <= r_cnt - c_ONE;
               // Last WAIT cycle lines up with the RAM's valid data
               if (r_cnt == c_ONE) begin
                  if (r_grant_mem) begin
                     r_mem_rdata <= bus.ram_rdata;
                  end else begin
                     r_if_rdata  <= bus.ram_rdata;
                  end
                  r_state <= c_S_DONE;
               end
            end
            c_S_DONE: begin
               r_state <= c_S_IDLE;
            end
            default: begin
               r_state <= c_S_IDLE;
            end
         endcase
      end
   end

   assign bus.ram_en         = (r_state == c_S_ISSUE);
   assign bus.ram_we         = r_ram_we;
   assign bus.ram_addr       = r_ram_addr;
   assign bus.ram_wdata      = r_ram_wdata;

   assign bus.if_ready       = w_if_ready;
   assign bus.if_rdata       = r_if_rdata;
   assign bus.if_stall       = bus.if_req & ~w_if_ready;

   assign bus.mem_ready      = w_mem_ready;
   assign bus.mem_rdata      = r_mem_rdata;
   assign bus.mem_stall      = bus.mem_req & ~w_mem_ready;

   assign bus.busy           = (r_state != c_S_IDLE);
   assign bus.last_grant_mem = r_last_grant_mem;
endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_mem_arbiter
//  Purpose  : Directed and randomized checks of shared_mem_arbiter against a
//             transaction-timestamp reference model.
//  Revision : 1.0
// ============================================================================
module tb_shared_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LAT    = 3;
   localparam int LAT_B  = 1;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;
   always #5 clk = ~clk;

   shared_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
   shared_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

   shared_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );
   shared_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one grant described by its decision cycle
   int          cyc = 0;
   int          t_g = -1000;
   bit          g_mem = 1'b0;
   bit          lgm = 1'b0;
   logic [31:0] l_addr, l_wdata, exp_rd;
   bit          l_we;
   bit          if_seen, mem_seen;

   // RAM macro environment
   logic [31:0] ram [256];
   int          rd_due = -1;
   logic [31:0] rd_val;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      return {22'd0, a[9:2], 2'b00};
   endfunction

   task automatic check_and_model();
      int n;
      bit busy_e, en_e, done_e, ifr_e, mr_e;
      n      = cyc;
      busy_e = (n > t_g) && (n <= t_g + LAT + 2);
      en_e   = (n == t_g + 1);
      done_e = (n == t_g + LAT + 2);
      ifr_e  = done_e && !g_mem && bus_a.if_req;
      mr_e   = done_e &&  g_mem && bus_a.mem_req;

      chk("busy", bus_a.busy, busy_e);
      chk("ram_en", bus_a.ram_en, en_e);
      if (en_e) begin
         chk("ram_addr", bus_a.ram_addr, l_addr);
         chk("ram_we", bus_a.ram_we, l_we);
         if (l_we) chk("ram_wdata", bus_a.ram_wdata, l_wdata);
         else exp_rd = ram[l_addr[9:2]];
      end
      chk("if_ready", bus_a.if_ready, ifr_e);
      chk("mem_ready", bus_a.mem_ready, mr_e);
      chk("if_stall", bus_a.if_stall, bus_a.if_req && !ifr_e);
      chk("mem_stall", bus_a.mem_stall, bus_a.mem_req && !mr_e);
      chk("last_grant_mem", bus_a.last_grant_mem, lgm);
      if (ifr_e) chk("if_rdata", bus_a.if_rdata, exp_rd);
      if (mr_e && !l_we) chk("mem_rdata", bus_a.mem_rdata, exp_rd);
      if_seen  = bus_a.if_ready;
      mem_seen = bus_a.mem_ready;

      if (bus_a.ram_en) begin
         if (bus_a.ram_we) ram[bus_a.ram_addr[9:2]] = bus_a.ram_wdata;
         else begin
            rd_due = n + LAT;
            rd_val = ram[bus_a.ram_addr[9:2]];
         end
      end

      if (rst) begin
         t_g = -1000;
         lgm = 1'b0;
      end else if (!busy_e && (bus_a.if_req || bus_a.mem_req)) begin
         // MEM is served unless IF is waiting and MEM had the previous turn
         g_mem   = bus_a.mem_req && !(bus_a.if_req && lgm);
         lgm     = g_mem;
         t_g     = n;
         l_addr  = g_mem ? bus_a.mem_addr : bus_a.if_addr;
         l_we    = g_mem && bus_a.mem_we;
         l_wdata = bus_a.mem_wdata;
      end
   endtask

   task automatic step();
      #1;
      check_and_model();
      @(posedge clk);
      #1;
      cyc++;
      bus_a.ram_rdata = (cyc == rd_due) ? rd_val : $urandom();
   endtask

   initial begin
      int en_b, rdy_b, busy_b, en_k, rdy_k, cnt;
      logic [31:0] rd_b, rd_k;
      int rdy_cyc[$];
      bit rdy_mem[$];
      bit if_pend, mem_pend;

      for (int i = 0; i < 256; i++) ram[i] = $urandom();
      ram[4] = 32'hDEAD_BEEF;
      {bus_a.if_req, bus_a.mem_req, bus_a.mem_we} = '0;
      {bus_b.if_req, bus_b.mem_req, bus_b.mem_we} = '0;
      bus_a.if_addr = '0; bus_a.mem_addr = '0; bus_a.mem_wdata = '0; bus_a.ram_rdata = '0;
      bus_b.if_addr = '0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0; bus_b.ram_rdata = '0;
      rst = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_lgm", bus_a.last_grant_mem, 0);
      chk("rst_ram_en", bus_a.ram_en, 0);
      chk("rst_ram_addr", bus_a.ram_addr, 0);
      chk("rst_ram_we", bus_a.ram_we, 0);
      chk("rst_ram_wdata", bus_a.ram_wdata, 0);
      chk("rst_if_rdata", bus_a.if_rdata, 0);
      chk("rst_mem_rdata", bus_a.mem_rdata, 0);
      chk("rst_b_busy", bus_b.busy, 0);
      rst = 1'b0;
      rst_b = 1'b0;

      // MEM_LAT=1 instance: load from 0x8
      en_b = -100; rdy_b = -100; busy_b = 0; rd_b = '0;
      bus_b.mem_addr = 32'h8;
      for (int k = 0; k < 7; k++) begin
         bus_b.mem_req   = (k <= 3);
         bus_b.ram_rdata = (k == en_b + LAT_B) ? 32'hCAFE_F00D : $urandom();
         #1;
         if (bus_b.ram_en) en_b = k;
         if (bus_b.mem_ready) begin
            rdy_b = k;
            rd_b  = bus_b.mem_rdata;
         end
         if (bus_b.busy) busy_b++;
         @(posedge clk);
         #1;
      end
      chk("b_ram_en_cycle", en_b, 1);
      chk("b_ready_cycle", rdy_b, 3);
      chk("b_rdata", rd_b, 32'hCAFE_F00D);
      chk("b_busy_cycles", busy_b, 3);

      // Single fetch from 0x10
      cyc = 0;
      en_k = -1; rdy_k = -1; rd_k = '0;
      bus_a.if_addr = 32'h10;
      for (int k = 0; k < 8; k++) begin
         bus_a.if_req = (k <= 5);
         #1;
         if (k <= 4) chk("t1_if_stall", bus_a.if_stall, 1);
         if (bus_a.ram_en) en_k = k;
         if (bus_a.if_ready) begin
            rdy_k = k;
            rd_k  = bus_a.if_rdata;
         end
         step();
      end
      chk("t1_ram_en_cycle", en_k, 1);
      chk("t1_ready_cycle", rdy_k, 5);
      chk("t1_if_rdata", rd_k, 32'hDEAD_BEEF);

      // Both requests after reset: MEM store first, then IF fetch
      rst = 1'b1; step(); rst = 1'b0;
      cyc = 0;
      rdy_cyc.delete();
      bus_a.mem_we = 1'b1; bus_a.mem_addr = 32'h40; bus_a.mem_wdata = 32'h1234;
      bus_a.if_addr = 32'h0;
      en_k = -1;
      for (int k = 0; k < 13; k++) begin
         bus_a.mem_req = (k <= 5);
         bus_a.if_req  = (k <= 11);
         #1;
         if (bus_a.ram_en && k > 1) en_k = k;
         if (bus_a.mem_ready || bus_a.if_ready) rdy_cyc.push_back(k);
         step();
      end
      chk("t2_ready_count", rdy_cyc.size(), 2);
      if (rdy_cyc.size() == 2) begin
         chk("t2_mem_ready_cycle", rdy_cyc[0], 5);
         chk("t2_if_ready_cycle", rdy_cyc[1], 11);
      end
      chk("t2_if_ram_en_cycle", en_k, 7);
      chk("t2_stored", ram[16], 32'h1234);

      // Both held across four grants: MEM, IF, MEM, IF
      cyc = 0;
      rdy_cyc.delete();
      rdy_mem.delete();
      bus_a.mem_we = 1'b0; bus_a.mem_addr = rand_addr(); bus_a.if_addr = rand_addr();
      for (int k = 0; k < 24; k++) begin
         bus_a.mem_req = 1'b1;
         bus_a.if_req  = 1'b1;
         #1;
         if (bus_a.mem_ready || bus_a.if_ready) begin
            rdy_cyc.push_back(k);
            rdy_mem.push_back(bus_a.mem_ready);
         end
         step();
      end
      bus_a.mem_req = 1'b0; bus_a.if_req = 1'b0;
      step();
      chk("t3_grant_count", rdy_cyc.size(), 4);
      for (int i = 0; i < rdy_cyc.size() && i < 4; i++) begin
         chk("t3_grant_is_mem", rdy_mem[i], (i % 2) == 0);
         chk("t3_grant_cycle", rdy_cyc[i], 5 + 6 * i);
      end

      // IF flushed during WAIT
      cyc = 0;
      cnt = 0; en_k = -1; busy_b = -1;
      bus_a.if_addr = 32'h20;
      for (int k = 0; k < 8; k++) begin
         bus_a.if_req = (k < 3);
         #1;
         if (bus_a.if_ready) cnt++;
         if (bus_a.ram_en) en_k = k;
         if (k == LAT + 3) busy_b = bus_a.busy;
         step();
      end
      chk("t4_if_ready_pulses", cnt, 0);
      chk("t4_ram_en_cycle", en_k, 1);
      chk("t4_idle_at_lat3", busy_b, 0);

      // Reset during WAIT aborts the access
      cyc = 0;
      cnt = 0; en_k = 0; busy_b = -1;
      bus_a.mem_addr = 32'h44; bus_a.mem_we = 1'b0;
      for (int k = 0; k < 11; k++) begin
         bus_a.mem_req = (k < 3);
         rst = (k == 3);
         #1;
         if (bus_a.mem_ready || bus_a.if_ready) cnt++;
         if (k >= 4 && bus_a.ram_en) en_k++;
         if (k == 4) busy_b = bus_a.busy;
         step();
      end
      rst = 1'b0;
      chk("t5_busy_after_rst", busy_b, 0);
      chk("t5_ready_pulses", cnt, 0);
      chk("t5_ram_en_after_rst", en_k, 0);

      // Randomized traffic with flushes, jitter and rare resets
      if_pend = 1'b0; mem_pend = 1'b0; if_seen = 1'b0; mem_seen = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if (if_pend && (if_seen || $urandom_range(0, 19) == 0)) if_pend = 1'b0;
         if (mem_pend && mem_seen) mem_pend = 1'b0;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            bus_a.if_addr = rand_addr();
         end else if (if_pend && bus_a.busy && $urandom_range(0, 3) == 0) begin
            bus_a.if_addr = rand_addr();
         end
         if (!mem_pend && $urandom_range(0, 2) == 0) begin
            mem_pend = 1'b1;
            bus_a.mem_addr  = rand_addr();
            bus_a.mem_we    = $urandom_range(0, 1) == 1;
            bus_a.mem_wdata = $urandom();
         end else if (mem_pend && bus_a.busy && $urandom_range(0, 3) == 0) begin
            bus_a.mem_addr  = rand_addr();
            bus_a.mem_wdata = $urandom();
         end
         bus_a.if_req  = if_pend;
         bus_a.mem_req = mem_pend;
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Shares one single-port, fixed-latency RAM between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sequences each access through a small FSM and returns a one-cycle ready pulse to the winning requester.
- Each stage freezes on `req & ~ready` using the provided stall outputs.
- Sits between IF_Stage/MEM_Stage and the shared RAM macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 3, cycles from ram_en to valid ram_rdata; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_ready  out  1  one-cycle completion pulse to IF
- if_rdata  out  DATA_W  fetched word; valid while if_ready
- if_stall  out  1  if_req & ~if_ready (combinational)
- mem_req  in  1  data request; held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_ready  out  1  one-cycle completion pulse to MEM
- mem_rdata  out  DATA_W  load data; valid while mem_ready
- mem_stall  out  1  mem_req & ~mem_ready (combinational)
- ram_en  out  1  one-cycle access strobe
- ram_we  out  1  write enable, qualified by ram_en
- ram_addr  out  ADDR_W  registered address
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the ram_en cycle
- busy  out  1  state != IDLE
- last_grant_mem  out  1  1 if most recent grant went to MEM

Behaviour:
- Reset: state IDLE; wait counter 0; last_grant_mem 0; all registered outputs 0.
  - Reset mid-access aborts the access: no ready pulse, no ram_en afterwards.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests at the clock edge.
  - Only mem_req: grant MEM.
  - Only if_req: grant IF.
  - Both: grant IF if last_grant_mem=1, else MEM. This gives MEM priority with anti-starvation alternation.
  - On grant: latch addr/we/wdata (IF always we=0) into ram_* registers, update last_grant_mem, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: exactly one cycle; ram_en=1, ram_we per latch; counter loads MEM_LAT; go to WAIT.
- WAIT: counter decrements every cycle.
  - When counter==1, capture ram_rdata into the granted requester's rdata register and go to DONE.
  - WAIT lasts exactly MEM_LAT cycles.
- DONE: one cycle; the granted ready=1 and its rdata held; go to IDLE unconditionally.
  - DONE never re-grants, because the requester advances at the edge ending DONE.
- Latency: req high in cycle 0 from IDLE → ram_en in cycle 1 → ready in cycle MEM_LAT+2.
  - Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Stores: identical timing; ready pulses; mem_rdata carries the captured (don't-care) ram_rdata, and the bench must not check it.
- Request dropped before grant (e.g. IF flush on branch): no effect; arbitration uses only the current cycle's reqs.
- Request dropped after grant: the RAM access completes (stores are never cancelled). The ready pulse is suppressed if that req is low during DONE.
- Only one ready may be high in any cycle. ram_en is never high outside ISSUE.
- Address/data changes on a held req after grant are ignored (latched values are used).

Test Plan:
- MEM_LAT=3, if_req=1, if_addr=0x10, RAM returns 0xDEADBEEF → ram_en in cycle 1 with ram_addr=0x10, ram_we=0; if_ready in cycle 5 with if_rdata=0xDEADBEEF; if_stall=1 in cycles 0–4.
- Both reqs from reset (last_grant_mem=0): mem store addr 0x40, data 0x1234, and if fetch 0x0 → MEM granted first: ram_we=1, ram_wdata=0x1234, mem_ready in cycle 5. IF is granted at the next IDLE (cycle 6): ram_en in cycle 7, if_ready in cycle 11.
- Both reqs continuously asserted for 4 grants → grants alternate MEM, IF, MEM, IF; last_grant_mem toggles each grant; never two consecutive IF grants while mem_req is pending.
- if_req drops during WAIT (flush) → ram access completes, if_ready stays 0 in DONE, FSM returns to IDLE at cycle MEM_LAT+3.
- rst asserted during WAIT → next cycle state IDLE, busy=0, no ready pulse, no further ram_en.
- MEM_LAT=1 sweep → load from 0x8 returns data with mem_ready in cycle 3; WAIT lasts exactly one cycle.
